// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display core: FSM state encoding,
// BCD digit limits, the fixed decimal-point mask and the BCD frame increment.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [3:0]  DIGIT_MAX     = 4'd9;
  localparam logic [3:0]  TENS_MAX      = 4'd5;
  localparam logic [3:0]  DP_MASK_SS_HH = 4'b1011;
  localparam logic [15:0] FRAME_LAST    = {TENS_MAX, DIGIT_MAX, DIGIT_MAX, DIGIT_MAX};

  // Advance an SS.hh frame by one hundredth; 59.99 rolls over to 00.00.
  function automatic logic [15:0] bcd_inc(input logic [15:0] frame);
    logic [3:0] ts, s, th, hh;
    {ts, s, th, hh} = frame;
    if (hh == DIGIT_MAX) begin
      hh = 4'd0;
      if (th == DIGIT_MAX) begin
        th = 4'd0;
        if (s == DIGIT_MAX) begin
          s  = 4'd0;
          ts = (ts == TENS_MAX) ? 4'd0 : ts + 4'd1;
        end else begin
          s = s + 4'd1;
        end
      end else begin
        th = th + 4'd1;
      end
    end else begin
      hh = hh + 4'd1;
    end
    return {ts, s, th, hh};
  endfunction

endpackage

// File: rtl/stopwatch_digit_core_btn_conditioner.sv
// btn_conditioner: two-flop synchroniser, optional debounce filter
// (STOPWATCH_DEBOUNCE_EN) and a single-cycle rising-edge pulse.
module btn_conditioner
`ifdef STOPWATCH_DEBOUNCE_EN
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
)
`endif
(
  input  logic CLK,
  input  logic RST,
  input  logic btn_raw,
  output logic btn_rise
);

  logic       sync1_q, sync2_q, prev_q, armed_q;
  logic [1:0] fill_q;
  logic       level;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fill_q  <= 2'b00;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) filt_d = sync2_q;
      else                                      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  // Edges are only honoured once the synchronised button has been seen low
  // after reset, so a button held through reset release is not a press.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q <= level;
      if (fill_q[1] && !sync2_q) armed_q <= 1'b1;
    end
  end

  assign btn_rise = level & ~prev_q & armed_q;

endmodule

// File: rtl/stopwatch_digit_core.sv
// stopwatch_digit_core: SS.hh stopwatch producing BCD frames for the display scanner.
// Define STOPWATCH_DEBOUNCE_EN to compile in the button debounce filters.
module stopwatch_digit_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1_000_000
`ifdef STOPWATCH_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        btn_start_stop,
  input  logic        btn_clear,
  output logic [15:0] digits,
  output logic [3:0]  dp_mask,
  output logic        frame_valid,
  output logic        running,
  output logic        wrap
);

  localparam int unsigned   PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [1:0]    btn_raw_vec, btn_rise_vec;
  logic          ss_rise, clr_rise;
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   digits_q, digits_d;
  logic          fv_q, fv_d, wrap_q, wrap_d;

  assign btn_raw_vec = {btn_clear, btn_start_stop};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    btn_conditioner
`ifdef STOPWATCH_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_cond (
        .CLK      (CLK),
        .RST      (RST),
        .btn_raw  (btn_raw_vec[gi]),
        .btn_rise (btn_rise_vec[gi])
      );
  end

  assign ss_rise  = btn_rise_vec[0];
  assign clr_rise = btn_rise_vec[1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      digits_q <= '0;
      fv_q     <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      digits_q <= digits_d;
      fv_q     <= fv_d;
      wrap_q   <= wrap_d;
    end
  end

  // In PAUSE a simultaneous clear beats start/stop; elsewhere start/stop wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ss_rise) state_d = ST_RUN;
      ST_RUN:   if (ss_rise) state_d = ST_PAUSE;
      ST_PAUSE: begin
        if (clr_rise)     state_d = ST_IDLE;
        else if (ss_rise) state_d = ST_RUN;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    presc_d  = presc_q;
    digits_d = digits_q;
    fv_d     = 1'b0;
    wrap_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (presc_q == PRESC_LAST) begin
          presc_d  = '0;
          digits_d = bcd_inc(digits_q);
          fv_d     = 1'b1;
          wrap_d   = (digits_q == FRAME_LAST);
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_PAUSE: begin
        if (clr_rise) begin
          presc_d  = '0;
          digits_d = '0;
          fv_d     = 1'b1;
        end
      end
      default: presc_d = '0;
    endcase
  end

  always_comb begin
    running     = (state_q == ST_RUN);
    dp_mask     = DP_MASK_SS_HH;
    digits      = digits_q;
    frame_valid = fv_q;
    wrap        = wrap_q;
  end

endmodule

// File: tb/tb_stopwatch_digit_core.sv
// Self-checking bench for stopwatch_digit_core: vector table, wrap/reset sequences
// and random button traffic against a centisecond-count reference model.
module tb_stopwatch_digit_core;

  localparam int unsigned TICK_DIV = 4;
`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int unsigned DEB = 8;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        btn_start_stop = 1'b0;
  logic        btn_clear = 1'b0;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        frame_valid, running, wrap;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  stopwatch_digit_core #(
    .TICK_DIV(TICK_DIV)
`ifdef STOPWATCH_DEBOUNCE_EN
    , .DEBOUNCE_CYCLES(DEB)
`endif
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .digits         (digits),
    .dp_mask        (dp_mask),
    .frame_valid    (frame_valid),
    .running        (running),
    .wrap           (wrap)
  );

  // Reference model: elapsed time as a plain centisecond count.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE} mstate_e;
  mstate_e m_state;
  int      m_centi, m_presc;
  bit      m_fv, m_wrap;
  bit      ss_h[$], cl_h[$];

  function automatic logic [15:0] to_bcd(input int c);
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_centi = 0; m_presc = 0; m_fv = 1'b0; m_wrap = 1'b0;
    ss_h.delete(); cl_h.delete();
  endtask

  // A press sampled at edge n acts at edge n+2, and needs a low sample before it.
  task automatic model_step(input bit ss_raw, input bit cl_raw);
    bit ss, cl;
    ss_h.push_back(ss_raw); if (ss_h.size() > 4) void'(ss_h.pop_front());
    cl_h.push_back(cl_raw); if (cl_h.size() > 4) void'(cl_h.pop_front());
    ss = (ss_h.size() == 4) && ss_h[1] && !ss_h[0];
    cl = (cl_h.size() == 4) && cl_h[1] && !cl_h[0];
    m_fv = 1'b0; m_wrap = 1'b0;
    case (m_state)
      M_IDLE: begin
        m_presc = 0;
        if (ss) m_state = M_RUN;
      end
      M_RUN: begin
        m_presc++;
        if (m_presc == TICK_DIV) begin
          m_presc = 0;
          m_centi = (m_centi + 1) % 6000;
          m_fv = 1'b1;
          m_wrap = (m_centi == 0);
        end
        if (ss) m_state = M_PAUSE;
      end
      default: begin
        if (cl) begin
          m_state = M_IDLE; m_centi = 0; m_presc = 0; m_fv = 1'b1;
        end else if (ss) m_state = M_RUN;
      end
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    bit m_run;
    m_run = (m_state == M_RUN);
    checks++;
    if ({digits, frame_valid, wrap, running, dp_mask} !==
        {to_bcd(m_centi), m_fv, m_wrap, m_run, 4'b1011}) begin
      errors++;
      $display("FAIL model @%0t: digits=%h fv=%b wrap=%b run=%b dp=%b, expected digits=%h fv=%b wrap=%b run=%b dp=1011",
               $time, digits, frame_valid, wrap, running, dp_mask,
               to_bcd(m_centi), m_fv, m_wrap, m_run);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step(btn_start_stop, btn_clear);
    #1;
    if (chk_en) check_model();
  endtask

  typedef struct {
    bit          ss;
    bit          cl;
    int          n;
    bit          run;
    logic [15:0] dig;
    bit          fv;
    bit          wr;
  } vec_t;

  vec_t tbl [25];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // ss, cl, cycles, then expected running, digits, frame_valid, wrap
    tbl[0]  = '{1'b1, 1'b0, 1,  1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1,  1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1,  1'b1, 16'h0000, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 3,  1'b1, 16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1,  1'b1, 16'h0001, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1,  1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 3,  1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 20, 1'b1, 16'h0007, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1,  1'b1, 16'h0007, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 2,  1'b0, 16'h0007, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 20, 1'b0, 16'h0007, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1,  1'b0, 16'h0007, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 2,  1'b1, 16'h0007, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1,  1'b1, 16'h0008, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1,  1'b1, 16'h0008, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 2,  1'b0, 16'h0008, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1,  1'b0, 16'h0008, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1,  1'b0, 16'h0008, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1,  1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 1,  1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 1,  1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 3,  1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[22] = '{1'b1, 1'b1, 1,  1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 2,  1'b1, 16'h0000, 1'b0, 1'b0};
    tbl[24] = '{1'b0, 1'b0, 4,  1'b1, 16'h0001, 1'b1, 1'b0};

    // Reset state
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("reset_digits", digits, 16'h0000);
    check("reset_dp_mask", dp_mask, 4'b1011);
    check("reset_running", running, 1'b0);
    check("reset_frame_valid", frame_valid, 1'b0);
    check("reset_wrap", wrap, 1'b0);
    $display("reset: digits=%h dp=%b run=%b fv=%b wrap=%b", digits, dp_mask, running, frame_valid, wrap);
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) cycle();

`ifndef STOPWATCH_DEBOUNCE_EN
    chk_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      btn_start_stop = tbl[i].ss;
      btn_clear      = tbl[i].cl;
      for (int k = 0; k < tbl[i].n; k++) cycle();
      check($sformatf("vec%0d", i), {running, digits, frame_valid, wrap},
            {tbl[i].run, tbl[i].dig, tbl[i].fv, tbl[i].wr});
      $display("vec %0d: ss=%b cl=%b run=%b digits=%h fv=%b wrap=%b",
               i, tbl[i].ss, tbl[i].cl, running, digits, frame_valid, wrap);
    end
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;

    // Run up to 59.98, then watch the rollover
    chk_en = 1'b0;
    n = 0;
    while (!(digits == 16'h5998 && frame_valid) && n < 30000) begin
      cycle();
      n++;
    end
    check("reach_5998_in_time", (n < 30000), 1'b1);
    chk_en = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    check("frame_5999", {digits, frame_valid, wrap, running}, {16'h5999, 1'b1, 1'b0, 1'b1});
    $display("tick: digits=%h fv=%b wrap=%b", digits, frame_valid, wrap);
    for (int k = 0; k < 4; k++) cycle();
    check("wrap_0000", {digits, frame_valid, wrap, running}, {16'h0000, 1'b1, 1'b1, 1'b1});
    $display("tick: digits=%h fv=%b wrap=%b", digits, frame_valid, wrap);
    cycle();
    check("wrap_one_cycle", {frame_valid, wrap}, 2'b00);

    // Asynchronous reset mid-run, with start/stop held through release
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check("async_reset", {running, digits, frame_valid, wrap, dp_mask},
          {1'b0, 16'h0000, 1'b0, 1'b0, 4'b1011});
    $display("async reset: run=%b digits=%h", running, digits);
    btn_start_stop = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    for (int k = 0; k < 10; k++) cycle();
    check("held_at_release_ignored", running, 1'b0);
    btn_start_stop = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    btn_start_stop = 1'b1;
    cycle();
    btn_start_stop = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    check("fresh_press_after_release", running, 1'b1);
    $display("press after release: run=%b", running);

    // Random button traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) btn_start_stop = ~btn_start_stop;
      if ($urandom_range(0, 17) == 0) btn_clear = ~btn_clear;
      cycle();
    end
    $display("random: 4000 cycles compared against model");
`else
    // Debounce: a 5-cycle glitch is filtered out
    btn_start_stop = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("glitch_no_run", running, 1'b0);
    end
    btn_start_stop = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      check("glitch_no_run", running, 1'b0);
    end
    $display("glitch: run=%b", running);
    // A 12-cycle press acts DEB cycles later than an undebounced one
    btn_start_stop = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k == 12) btn_start_stop = 1'b0;
      cycle();
      check($sformatf("debounced_press_k%0d", k), running, (k >= 2 + DEB));
    end
    $display("debounced press: run=%b", running);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
